clocked_video_rx: RTL
=====================

CLOCKED_VIDEO_RX -- requirements
Module: clocked_video_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, >=4): output FIFO entries.
REQ-002 SHALL have parameter DATA_W, default 24: pixel width (8:8:8 RGB).
REQ-003 clk_clk  in  1  single clock; all logic on rising edge; video source is synchronous to it.
REQ-004 reset_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 vid_data  in  DATA_W  pixel data, sampled when vid_datavalid=1.
REQ-006 vid_datavalid  in  1  active-pixel qualifier.
REQ-007 vid_h_sync  in  1  line sync, active-high.
REQ-008 vid_v_sync  in  1  frame sync, active-high.
REQ-009 dout_data  out  DATA_W  streamed pixel.
REQ-010 dout_valid  out  1  dout_* valid.
REQ-011 dout_ready  in  1  sink accepts; transfer = dout_valid & dout_ready.
REQ-012 dout_startofpacket  out  1  first pixel of frame.
REQ-013 dout_endofpacket  out  1  last pixel of frame.
REQ-014 overflow  out  1  sticky FIFO overflow flag.
REQ-015 overflow_clr  in  1  clears overflow.
REQ-016 line_width  out  12  pixels per line of last completed frame.
REQ-017 frame_height  out  12  lines of last completed frame.
REQ-018 locked  out  1  two consecutive identical, non-zero frame geometries.

Function
REQ-019 Inputs SHALL be registered once; sync rising edges SHALL be detected on registered values (0 then 1).
REQ-020 States SHALL be SEEK, ARMED, ACTIVE, DROP.
REQ-021 SEEK: all pixels discarded; v_sync rise -> ARMED.
REQ-022 ARMED: next pixel SHALL be loaded into the hold register tagged SOP; -> ACTIVE.
REQ-023 ACTIVE: each new pixel SHALL push the held pixel into the FIFO and load itself into hold.
REQ-024 ACTIVE: v_sync rise SHALL push the held pixel tagged EOP, latch geometry, -> ARMED.
REQ-025 A push while FIFO count == FIFO_DEPTH SHALL be refused (simultaneous pop not credited): set overflow, drop the new pixel, -> DROP.
REQ-026 DROP: held pixel SHALL be pushed tagged EOP at the first cycle with space; remaining pixels discarded; v_sync rise (after EOP push) -> ARMED; geometry not latched for that frame.
REQ-027 FIFO SHALL be first-word fall-through; dout_valid SHALL rise the cycle after the write into an empty FIFO.
REQ-028 dout_* SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-029 Pixel counter SHALL count pixels since last h_sync rise; at h_sync rise a non-zero count SHALL be recorded as current width and increment the line counter.
REQ-030 At v_sync rise in ACTIVE a pending non-zero line SHALL be counted; line_width/frame_height SHALL update with that frame's values; counters SHALL clear.
REQ-031 Counters SHALL saturate at 4095.
REQ-032 locked SHALL set when latched geometry equals previous non-zero geometry; clear on mismatch or overflow event.
REQ-033 overflow_clr SHALL clear overflow next cycle; a simultaneous new overflow SHALL win (overflow stays 1).

Reset
REQ-034 Reset SHALL immediately force: state SEEK, FIFO empty, hold empty, dout_valid/sop/eop 0, dout_data 0, overflow 0, locked 0, line_width 0, frame_height 0, all counters 0.
REQ-035 Reset mid-frame SHALL drop the partial frame; the next emitted pixel SHALL be SOP of a frame beginning after a v_sync rise.

Verification
REQ-036 Reset; v_sync pulse; 3 lines x 4 pixels (data 0..11), h_sync between lines; v_sync; repeat; dout_ready=1 -> 0..11 twice, SOP on 0, EOP on 11, line_width=4, frame_height=3, locked=1 after second v_sync.
REQ-037 dout_ready=0, FIFO_DEPTH=16, 40-pixel frame -> overflow=1 on pixel 18; raise dout_ready -> exactly 17 pixels, 0..16, EOP on 16; locked=0.
REQ-038 overflow=1; overflow_clr one cycle -> overflow=0; overflow_clr coincident with new overflow -> overflow=1.
REQ-039 5 pixels after reset with no v_sync -> dout_valid stays 0.
REQ-040 Reset asserted at pixel 6 of a frame -> dout_valid=0 asynchronously; after release, next output is SOP of the frame following a v_sync.
REQ-041 Frame 4x3 then 5x3 -> line_width=5, frame_height=3, locked=0 after second frame.

Source files
------------

// File: rtl/clocked_video_rx.sv
// Clocked-video receiver: syncs a pixel stream with h/v sync into a
// packetised FWFT stream, measuring frame geometry and lock status.
module clocked_video_rx #(
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = 24
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [DATA_W-1:0] vid_data,
   input  logic              vid_datavalid,
   input  logic              vid_h_sync,
   input  logic              vid_v_sync,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_startofpacket,
   output logic              dout_endofpacket,
   output logic              overflow,
   input  logic              overflow_clr,
   output logic [11:0]       line_width,
   output logic [11:0]       frame_height,
   output logic              locked
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_W + 2;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CONE    = 1;
   localparam logic [AW-1:0] PONE    = 1;
   localparam logic [11:0]   SAT     = 12'hFFF;

   typedef enum logic [1:0] {SEEK, ARMED, ACTIVE, DROP} state_t;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == SAT) ? v : v + 12'd1;
   endfunction

   logic [DATA_W-1:0] data_r;
   logic              dv_r, hs_r, vs_r, hs_q, vs_q;
   logic              hs_rise, vs_rise;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         data_r <= '0;
         dv_r   <= 1'b0;
         hs_r   <= 1'b0;
         vs_r   <= 1'b0;
         hs_q   <= 1'b0;
         vs_q   <= 1'b0;
      end else begin
         data_r <= vid_data;
         dv_r   <= vid_datavalid;
         hs_r   <= vid_h_sync;
         vs_r   <= vid_v_sync;
         hs_q   <= hs_r;
         vs_q   <= vs_r;
      end
   end

   assign hs_rise = hs_r & ~hs_q;
   assign vs_rise = vs_r & ~vs_q;

   // FIFO entry layout: {sop, eop, data}
   logic [EW-1:0]     mem [FIFO_DEPTH];
   logic [EW-1:0]     rd_e;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              full, pop, push_ok;
   logic              push_req, push_eop;
   logic [DATA_W-1:0] hold_data;
   logic              hold_sop, hold_valid;

   assign full    = (count == DEPTH_C);
   assign push_ok = push_req & ~full;
   assign pop     = dout_valid & dout_ready;
   assign rd_e    = mem[rd_ptr];

   assign dout_valid         = (count != '0);
   assign dout_data          = dout_valid ? rd_e[DATA_W-1:0] : '0;
   assign dout_endofpacket   = dout_valid & rd_e[DATA_W];
   assign dout_startofpacket = dout_valid & rd_e[DATA_W+1];

   always_ff @(posedge clk_clk) begin
      if (push_ok) mem[wr_ptr] <= {hold_sop, push_eop, hold_data};
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PONE;
         if (pop)     rd_ptr <= rd_ptr + PONE;
         unique case ({push_ok, pop})
            2'b10:   count <= count + CONE;
            2'b01:   count <= count - CONE;
            default: count <= count;
         endcase
      end
   end

   state_t state, state_nx;
   logic   load, load_sop, hold_clr, geo_latch, ov_set;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) state <= SEEK;
      else                state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         SEEK:   if (vs_rise) state_nx = ARMED;
         ARMED:  if (dv_r) state_nx = ACTIVE;
         ACTIVE: begin
            if (ov_set)       state_nx = DROP;
            else if (vs_rise) state_nx = ARMED;
         end
         DROP:   if (vs_rise && (!hold_valid || !full)) state_nx = ARMED;
         default: state_nx = SEEK;
      endcase
   end

   always_comb begin
      push_req  = 1'b0;
      push_eop  = 1'b0;
      load      = 1'b0;
      load_sop  = 1'b0;
      hold_clr  = 1'b0;
      geo_latch = 1'b0;
      unique case (state)
         ARMED: if (dv_r) begin
            load     = 1'b1;
            load_sop = 1'b1;
         end
         ACTIVE: begin
            if (vs_rise) begin
               push_req  = 1'b1;
               push_eop  = 1'b1;
               hold_clr  = ~full;
               geo_latch = ~full;
            end else if (dv_r) begin
               push_req = 1'b1;
               load     = ~full;
            end
         end
         DROP: if (hold_valid) begin
            push_req = 1'b1;
            push_eop = 1'b1;
            hold_clr = ~full;
         end
         default: ;
      endcase
   end

   assign ov_set = push_req & full;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         hold_data  <= '0;
         hold_sop   <= 1'b0;
         hold_valid <= 1'b0;
      end else if (load) begin
         hold_data  <= data_r;
         hold_sop   <= load_sop;
         hold_valid <= 1'b1;
      end else if (hold_clr) begin
         hold_valid <= 1'b0;
      end
   end

   logic [11:0] pix_cnt, line_cnt, cur_width, frame_w, frame_h;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pix_cnt   <= '0;
         line_cnt  <= '0;
         cur_width <= '0;
      end else if (vs_rise) begin
         pix_cnt   <= '0;
         line_cnt  <= '0;
         cur_width <= '0;
      end else if (hs_rise) begin
         pix_cnt <= dv_r ? 12'd1 : 12'd0;
         if (pix_cnt != '0) begin
            cur_width <= pix_cnt;
            line_cnt  <= sat_inc(line_cnt);
         end
      end else if (dv_r) begin
         pix_cnt <= sat_inc(pix_cnt);
      end
   end

   // A line still open at v_sync counts as the frame's last line
   assign frame_w = (pix_cnt != '0) ? pix_cnt : cur_width;
   assign frame_h = (pix_cnt != '0) ? sat_inc(line_cnt) : line_cnt;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         line_width   <= '0;
         frame_height <= '0;
         locked       <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (geo_latch) begin
            line_width   <= frame_w;
            frame_height <= frame_h;
            locked       <= (frame_w != '0) && (frame_h != '0) &&
                            (frame_w == line_width) &&
                            (frame_h == frame_height);
         end else if (ov_set) begin
            locked <= 1'b0;
         end
         if (ov_set)            overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

endmodule
